// File: rtl/puf_response_collector.sv
// puf_response_collector
// Drives the reset/trigger sequence of a 16-bit arbiter-PUF array NUM_EVAL
// times per challenge. It synchronises and counts the arbiter outputs, then
// returns a majority-voted response together with a per-bit instability mask.
module puf_response_collector #(
    parameter int NUM_EVAL      = 8,
    parameter int ARM_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         chal_valid,
    output logic         chal_ready,
    input  logic [127:0] chal_data,
    input  logic [15:0]  ex_a,
    input  logic [15:0]  ex_b,
    output logic [127:0] puf_challenge,
    output logic [15:0]  puf_a,
    output logic [15:0]  puf_b,
    output logic         puf_trigger,
    output logic         puf_reset,
    input  logic [15:0]  puf_response,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [15:0]  resp_data,
    output logic [15:0]  resp_unstable
);

    localparam int CW = $clog2(NUM_EVAL + 1);

    localparam logic [7:0]    ARM_LAST  = 8'(ARM_CYCLES - 1);
    localparam logic [7:0]    FIRE_LAST = 8'(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] N_CNT     = CW'(NUM_EVAL);
    localparam logic [CW:0]   N_DBL     = (CW + 1)'(NUM_EVAL);

    typedef enum logic [1:0] {IDLE, ARM, FIRE, DONE} state_t;

    state_t        state;
    logic [15:0]   sync_meta;
    logic [15:0]   sync_resp;
    logic [CW-1:0] cnt [16];
    logic [7:0]    eval_cnt;
    logic [7:0]    phase_cnt;
    logic [15:0]   vote_data;
    logic [15:0]   vote_unstable;
    logic          last_eval;

    // The evaluation finishing now is the last one of the job.
    assign last_eval = ({1'b0, eval_cnt} + 9'd1) >= 9'(NUM_EVAL);

    // Two-flop synchroniser on the asynchronous arbiter outputs, free running.
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '0;
            sync_resp <= '0;
        end else begin
            sync_meta <= puf_response;
            sync_resp <= sync_meta;
        end
    end

    // Majority vote and disagreement mask derived from the per-bit counters.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        vote_data     = '0;
        vote_unstable = '0;
        for (int i = 0; i < 16; i++) begin
            vote_data[i]     = {cnt[i], 1'b0} > N_DBL;
            vote_unstable[i] = (cnt[i] != '0) && (cnt[i] != N_CNT);
        end
    end

    // Job sequencer: handshakes, arm/fire timing, vote counting and result.
    // NOTE: the vote counters are a small register array rather than RAM, so
    // they take the asynchronous reset like any other state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            chal_ready    <= 1'b1;
            puf_reset     <= 1'b1;
            puf_trigger   <= 1'b0;
            puf_challenge <= '0;
            puf_a         <= '0;
            puf_b         <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_unstable <= '0;
            eval_cnt      <= '0;
            phase_cnt     <= '0;
            for (int i = 0; i < 16; i++) cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (chal_valid && chal_ready) begin
                        puf_challenge <= chal_data;
                        puf_a         <= ex_a;
                        puf_b         <= ex_b;
                        eval_cnt      <= '0;
                        phase_cnt     <= '0;
                        chal_ready    <= 1'b0;
                        for (int i = 0; i < 16; i++) cnt[i] <= '0;
                        state         <= ARM;
                    end
                end
                ARM: begin
                    if (phase_cnt == ARM_LAST) begin
                        phase_cnt   <= '0;
                        puf_reset   <= 1'b0;
                        puf_trigger <= 1'b1;
                        state       <= FIRE;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                FIRE: begin
                    if (phase_cnt == FIRE_LAST) begin
                        for (int i = 0; i < 16; i++) begin
                            if (cnt[i] != N_CNT) cnt[i] <= cnt[i] + CW'(sync_resp[i]);
                        end
                        eval_cnt    <= eval_cnt + 8'd1;
                        phase_cnt   <= '0;
                        puf_trigger <= 1'b0;
                        puf_reset   <= 1'b1;
                        state       <= last_eval ? DONE : ARM;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                DONE: begin
                    if (!resp_valid) begin
                        resp_data     <= vote_data;
                        resp_unstable <= vote_unstable;
                        resp_valid    <= 1'b1;
                    end else if (resp_ready) begin
                        resp_valid <= 1'b0;
                        chal_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_response_collector.sv
// Testbench for puf_response_collector: a behavioural PUF plus a vote model
// that counts ones per bit across the evaluations of each job.
module tb_puf_response_collector;

    localparam int NE  = 8;
    localparam int AC  = 4;
    localparam int SC  = 16;
    localparam int LAT = 1 + NE * (AC + SC + 2);
    localparam int NE2 = 2;
    localparam int AC2 = 2;
    localparam int SC2 = 3;
    localparam int LAT2 = 1 + NE2 * (AC2 + SC2 + 2);

    logic         clk = 1'b0;
    logic         reset_n;
    logic         chal_valid;
    logic         chal_ready;
    logic [127:0] chal_data;
    logic [15:0]  ex_a;
    logic [15:0]  ex_b;
    logic [127:0] puf_challenge;
    logic [15:0]  puf_a;
    logic [15:0]  puf_b;
    logic         puf_trigger;
    logic         puf_reset;
    logic [15:0]  puf_response = '0;
    logic         resp_valid;
    logic         resp_ready;
    logic [15:0]  resp_data;
    logic [15:0]  resp_unstable;

    logic         c2_valid;
    logic         c2_ready;
    logic [127:0] c2_data;
    logic [127:0] p2_challenge;
    logic [15:0]  p2_a;
    logic [15:0]  p2_b;
    logic         p2_trigger;
    logic         p2_reset;
    logic [15:0]  p2_response = '0;
    logic         r2_valid;
    logic [15:0]  r2_data;
    logic [15:0]  r2_unstable;

    int n_vec  = 0;
    int n_fail = 0;

    // PUF stimulus: pattern e is presented on the e-th trigger of a job.
    logic [15:0] pat  [256];
    logic [15:0] pat2 [256];
    int job_gen  = 0;
    int job_gen2 = 0;
    int gen_seen  = 0;
    int gen_seen2 = 0;
    int eval_idx  = 0;
    int eval_idx2 = 0;

    // Waveform statistics gathered while waiting for a response.
    int tw[$];
    int rw[$];
    int overlap;

    always #5 clk = ~clk;

    puf_response_collector #(.NUM_EVAL(NE), .ARM_CYCLES(AC), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset_n(reset_n),
        .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_data(chal_data),
        .ex_a(ex_a), .ex_b(ex_b),
        .puf_challenge(puf_challenge), .puf_a(puf_a), .puf_b(puf_b),
        .puf_trigger(puf_trigger), .puf_reset(puf_reset), .puf_response(puf_response),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_unstable(resp_unstable)
    );

    puf_response_collector #(.NUM_EVAL(NE2), .ARM_CYCLES(AC2), .SETTLE_CYCLES(SC2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .chal_valid(c2_valid), .chal_ready(c2_ready), .chal_data(c2_data),
        .ex_a(16'h0000), .ex_b(16'h0000),
        .puf_challenge(p2_challenge), .puf_a(p2_a), .puf_b(p2_b),
        .puf_trigger(p2_trigger), .puf_reset(p2_reset), .puf_response(p2_response),
        .resp_valid(r2_valid), .resp_ready(1'b1),
        .resp_data(r2_data), .resp_unstable(r2_unstable)
    );

    // Behavioural PUF for the default instance.
    always @(posedge puf_trigger) begin
        if (gen_seen != job_gen) begin
            gen_seen = job_gen;
            eval_idx = 0;
        end
        puf_response = (eval_idx < 256) ? pat[eval_idx] : 16'h0000;
        eval_idx++;
    end

    // Behavioural PUF for the two-evaluation instance.
    always @(posedge p2_trigger) begin
        if (gen_seen2 != job_gen2) begin
            gen_seen2 = job_gen2;
            eval_idx2 = 0;
        end
        p2_response = (eval_idx2 < 256) ? pat2[eval_idx2] : 16'h0000;
        eval_idx2++;
    end

    // Hard stop in case something escapes the bounded waits.
    initial begin
        #1ms;
        $display("FAIL watchdog: observed no end of test, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference vote: count ones per bit over the n evaluations.
    function automatic void ref_vote(input logic [15:0] p [256], input int n,
                                     output logic [15:0] d, output logic [15:0] u);
        d = '0;
        u = '0;
        for (int b = 0; b < 16; b++) begin
            int ones = 0;
            for (int e = 0; e < n; e++) ones += int'(p[e][b]);
            d[b] = (2 * ones) > n;
            u[b] = (ones != 0) && (ones != n);
        end
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_job(input logic [127:0] c, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        check("accept_ready", 128'(chal_ready), 128'(1));
        chal_valid = 1'b1;
        chal_data  = c;
        ex_a       = a;
        ex_b       = b;
        @(posedge clk);
        #1;
        chal_valid = 1'b0;
        chal_data  = rand128();
        ex_a       = 16'($urandom);
        ex_b       = 16'($urandom);
    endtask

    // Waits for resp_valid; lat counts edges after the acceptance edge.
    task automatic wait_resp(output int lat);
        int trun = 0;
        int rrun = 0;
        tw.delete();
        rw.delete();
        overlap = 0;
        lat = 0;
        @(negedge clk);
        while (1) begin
            if (puf_trigger && puf_reset) overlap++;
            if (puf_trigger) trun++;
            else if (trun != 0) begin tw.push_back(trun); trun = 0; end
            if (puf_reset) rrun++;
            else if (rrun != 0) begin rw.push_back(rrun); rrun = 0; end
            if (resp_valid || lat >= 1000) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_check(input string tag);
        logic [127:0] c;
        logic [15:0]  a, b, ed, eu;
        int lat;
        c = rand128();
        a = 16'($urandom);
        b = 16'($urandom);
        ref_vote(pat, NE, ed, eu);
        job_gen++;
        start_job(c, a, b);
        wait_resp(lat);
        check({tag, "_latency"}, 128'(lat), 128'(LAT));
        check({tag, "_data"}, 128'(resp_data), 128'(ed));
        check({tag, "_unstable"}, 128'(resp_unstable), 128'(eu));
        check({tag, "_challenge"}, puf_challenge, c);
        check({tag, "_ab"}, 128'({puf_a, puf_b}), 128'({a, b}));
        @(posedge clk);
        #1;
        check({tag, "_handshake"}, 128'({resp_valid, chal_ready}), 128'(2'b01));
    endtask

    task automatic run2(input string tag);
        logic [15:0] ed, eu;
        int lat;
        ref_vote(pat2, NE2, ed, eu);
        job_gen2++;
        @(negedge clk);
        c2_valid = 1'b1;
        c2_data  = rand128();
        @(posedge clk);
        #1;
        c2_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!r2_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(LAT2));
        check({tag, "_data"}, 128'(r2_data), 128'(ed));
        check({tag, "_unstable"}, 128'(r2_unstable), 128'(eu));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_chal_ready"}, 128'(chal_ready), 128'(1));
        check({tag, "_puf_reset"}, 128'(puf_reset), 128'(1));
        check({tag, "_puf_trigger"}, 128'(puf_trigger), 128'(0));
        check({tag, "_puf_challenge"}, puf_challenge, 128'(0));
        check({tag, "_puf_ab"}, 128'({puf_a, puf_b}), 128'(0));
        check({tag, "_resp_valid"}, 128'(resp_valid), 128'(0));
        check({tag, "_resp"}, 128'({resp_data, resp_unstable}), 128'(0));
    endtask

    initial begin
        int lat;
        int bad;
        logic [127:0] c1, c2;
        logic [15:0]  a2, b2, hd, hu, ed, eu;
        int bad_v, bad_d, bad_r, bad_c;

        reset_n    = 1'b0;
        chal_valid = 1'b0;
        chal_data  = '0;
        ex_a       = '0;
        ex_b       = '0;
        resp_ready = 1'b1;
        c2_valid   = 1'b0;
        c2_data    = '0;
        for (int e = 0; e < 256; e++) begin
            pat[e]  = '0;
            pat2[e] = '0;
        end

        // Reset values.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_values("rst");

        // Stable PUF with waveform checks.
        for (int e = 0; e < NE; e++) pat[e] = 16'hA5C3;
        run_check("stable");
        check("stable_trig_pulses", 128'(tw.size()), 128'(NE));
        check("stable_reset_pulses", 128'(rw.size()), 128'(NE));
        bad = 0;
        foreach (tw[i]) if (tw[i] != SC + 2) bad++;
        foreach (rw[i]) if (rw[i] != AC) bad++;
        check("stable_pulse_widths", 128'(bad), 128'(0));
        check("stable_overlap", 128'(overlap), 128'(0));

        // Noisy PUF: five A5C3, three 5A3C.
        pat[0] = 16'hA5C3; pat[1] = 16'h5A3C; pat[2] = 16'hA5C3; pat[3] = 16'hA5C3;
        pat[4] = 16'h5A3C; pat[5] = 16'hA5C3; pat[6] = 16'h5A3C; pat[7] = 16'hA5C3;
        run_check("noisy");

        // Randomised jobs: a base word with sparse per-evaluation noise.
        for (int j = 0; j < 4; j++) begin
            logic [15:0] base, mask;
            base = 16'($urandom);
            mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
            for (int e = 0; e < NE; e++) pat[e] = base ^ (16'($urandom) & mask);
            run_check($sformatf("rand%0d", j));
        end

        // Backpressure: response held while a new challenge waits.
        for (int e = 0; e < NE; e++) pat[e] = 16'($urandom);
        ref_vote(pat, NE, ed, eu);
        resp_ready = 1'b0;
        c1 = rand128();
        job_gen++;
        start_job(c1, 16'h1111, 16'h2222);
        wait_resp(lat);
        check("bp_latency", 128'(lat), 128'(LAT));
        check("bp_data", 128'({resp_data, resp_unstable}), 128'({ed, eu}));
        hd = resp_data;
        hu = resp_unstable;
        for (int e = 0; e < NE; e++) pat[e] = 16'($urandom);
        ref_vote(pat, NE, ed, eu);
        job_gen++;
        c2 = rand128();
        a2 = 16'($urandom);
        b2 = 16'($urandom);
        chal_valid = 1'b1;
        chal_data  = c2;
        ex_a       = a2;
        ex_b       = b2;
        bad_v = 0; bad_d = 0; bad_r = 0; bad_c = 0;
        repeat (50) begin
            @(negedge clk);
            if (resp_valid !== 1'b1) bad_v++;
            if (resp_data !== hd || resp_unstable !== hu) bad_d++;
            if (chal_ready !== 1'b0) bad_r++;
            if (puf_challenge !== c1) bad_c++;
        end
        check("bp_valid_held", 128'(bad_v), 128'(0));
        check("bp_data_held", 128'(bad_d), 128'(0));
        check("bp_chal_blocked", 128'(bad_r), 128'(0));
        check("bp_challenge_held", 128'(bad_c), 128'(0));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_m_state", 128'({resp_valid, chal_ready}), 128'(2'b01));
        check("bp_m_challenge", puf_challenge, c1);
        @(posedge clk);
        #1;
        chal_valid = 1'b0;
        check("bp_m1_ready", 128'(chal_ready), 128'(0));
        check("bp_m1_challenge", puf_challenge, c2);
        check("bp_m1_ab", 128'({puf_a, puf_b}), 128'({a2, b2}));
        wait_resp(lat);
        check("bp2_latency", 128'(lat), 128'(LAT));
        check("bp2_data", 128'({resp_data, resp_unstable}), 128'({ed, eu}));
        @(posedge clk);
        #1;

        // Reset in the middle of a job, then a clean constant job.
        for (int e = 0; e < NE; e++) pat[e] = 16'($urandom);
        job_gen++;
        start_job(rand128(), 16'($urandom), 16'($urandom));
        repeat (60) @(negedge clk);
        check("mid_trigger_active", 128'(puf_trigger), 128'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int e = 0; e < NE; e++) pat[e] = 16'h1234;
        run_check("after_rst");

        // Two-evaluation instance: tie resolves to zero, agreement is stable.
        pat2[0] = 16'hFFFF;
        pat2[1] = 16'h0000;
        run2("tie");
        check("tie_expected_zero", 128'(r2_data), 128'(16'h0000));
        pat2[1] = 16'hFFFF;
        run2("agree2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
